alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the nic8 datapath family. It generalises the 8-bit add/subtract/shift ALU to `WIDTH` bits and adds logic ops, compare and carry-chained subtract. It also adds an optional iterative unsigned multiplier behind a start/busy/done handshake. Results and flags are registered, so the control sequencer reads `result` and the flags after `done` and drives the data bus from them.

---
 rtl/alu_mc.sv | 169 ++++++++++++++++
 tb/tb_alu_mc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: WIDTH-bit multi-cycle ALU for the nic8 datapath family.
// Single-cycle ADD/SUB/AND/OR/XOR/SHR/CMP, plus an iterative unsigned
// shift-add MUL (W cycles) behind a start/busy/done handshake.
// Results and flags are registered; sequencer reads them after done.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   start      operation request, sampled only while busy=0
//   op         0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHR,6 MUL,7 CMP
//   useCarry   chain ADD/SUB/CMP on flagCarry
//   a, b       operands, sampled with start
//   busy       high while MUL iterates
//   done       one-cycle completion pulse
//   result     low result (low product half for MUL)
//   resultHi   high product half, written only by MUL
//   flagCarry, flagShift, flagZero  status flags
module alu_mc #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             useCarry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHi,
  output logic             flagCarry,
  output logic             flagShift,
  output logic             flagZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHR = 3'd5, OP_MUL = 3'd6, OP_CMP = 3'd7
  } op_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   result_d, resulthi_d;
  logic               fc_d, fs_d, fz_d, done_d;
  logic [WIDTH-1:0]   ma, ma_d;
  // prod holds {partial sum, remaining multiplier bits}; after W steps it
  // is the full 2W product.
  logic [2*WIDTH-1:0] prod, prod_d, step_prod;
  logic [CW-1:0]      count, count_d;
  logic [WIDTH:0]     sum, diff, step_sum;
  logic               ci, bi;

  assign busy = (state == S_MUL);

  always_comb begin
    state_d    = state;
    result_d   = result;
    resulthi_d = resultHi;
    fc_d       = flagCarry;
    fs_d       = flagShift;
    fz_d       = flagZero;
    done_d     = 1'b0;
    ma_d       = ma;
    prod_d     = prod;
    count_d    = count;

    ci   = useCarry & flagCarry;
    bi   = useCarry & ~flagCarry;
    sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};

    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : '0);
    step_prod = {step_sum, prod[WIDTH-1:1]};

    case (state)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          case (op_t'(op))
            OP_ADD: begin
              result_d = sum[WIDTH-1:0];
              fc_d     = sum[WIDTH];
              fz_d     = (sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
              result_d = diff[WIDTH-1:0];
              fc_d     = ~diff[WIDTH];
              fz_d     = (diff[WIDTH-1:0] == '0);
            end
            OP_CMP: begin
              fc_d = ~diff[WIDTH];
              fz_d = (diff[WIDTH-1:0] == '0);
            end
            OP_AND: begin
              result_d = a & b;
              fz_d     = ((a & b) == '0);
            end
            OP_OR: begin
              result_d = a | b;
              fz_d     = ((a | b) == '0);
            end
            OP_XOR: begin
              result_d = a ^ b;
              fz_d     = ((a ^ b) == '0);
            end
            OP_SHR: begin
              result_d = {flagShift, a[WIDTH-1:1]};
              fs_d     = a[0];
              fz_d     = ({flagShift, a[WIDTH-1:1]} == '0);
            end
            OP_MUL: begin
              if (MUL_EN != 0) begin
                done_d  = 1'b0;
                state_d = S_MUL;
                ma_d    = a;
                prod_d  = {{WIDTH{1'b0}}, b};
                count_d = CW'(WIDTH);
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        prod_d  = step_prod;
        count_d = count - CW'(1);
        if (count == CW'(1)) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          result_d   = step_prod[WIDTH-1:0];
          resulthi_d = step_prod[2*WIDTH-1:WIDTH];
          fc_d       = (step_prod[2*WIDTH-1:WIDTH] != '0);
          fz_d       = (step_prod == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      result    <= '0;
      resultHi  <= '0;
      flagCarry <= 1'b0;
      flagShift <= 1'b0;
      flagZero  <= 1'b0;
      done      <= 1'b0;
      ma        <= '0;
      prod      <= '0;
      count     <= '0;
    end else begin
      state     <= state_d;
      result    <= result_d;
      resultHi  <= resulthi_d;
      flagCarry <= fc_d;
      flagShift <= fs_d;
      flagZero  <= fz_d;
      done      <= done_d;
      ma        <= ma_d;
      prod      <= prod_d;
      count     <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=8, MUL_EN=1).
module tb_alu_mc;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHR = 3'd5, MUL = 3'd6, CMP = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic       useCarry = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done;
  logic [7:0] result, resultHi;
  logic       flagCarry, flagShift, flagZero;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_mc #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .useCarry(useCarry),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .resultHi(resultHi), .flagCarry(flagCarry), .flagShift(flagShift),
    .flagZero(flagZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op at a negedge, let it be sampled, return 1ns after the edge.
  task automatic apply(input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic uc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; useCarry = uc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] r,
                           input logic c, input logic s, input logic z);
    check({tag, ".done"},  done, 1);
    check({tag, ".res"},   result, r);
    check({tag, ".carry"}, flagCarry, c);
    check({tag, ".shift"}, flagShift, s);
    check({tag, ".zero"},  flagZero, z);
  endtask

  initial begin
    // Reset state
    #12 reset = 1'b0;
    check("rst.res", result, 0);
    check("rst.hi", resultHi, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.flags", {flagCarry, flagShift, flagZero}, 0);

    // ADD and carry chain
    apply(ADD, 8'hF0, 8'h20, 1'b0);
    check_out("add1", 8'h10, 1, 0, 0);
    check("add1.busy", busy, 0);
    @(posedge clk); #1;
    check("add1.pulse", done, 0);
    apply(ADD, 8'h01, 8'h01, 1'b1);
    check_out("addc", 8'h03, 0, 0, 0);

    // SUB / CMP
    apply(SUB, 8'h05, 8'h05, 1'b0);
    check_out("sub0", 8'h00, 1, 0, 1);
    apply(SUB, 8'h03, 8'h05, 1'b0);
    check_out("subb", 8'hFE, 0, 0, 0);
    apply(SUB, 8'h10, 8'h0F, 1'b1);
    check_out("subc", 8'h00, 1, 0, 1);
    apply(CMP, 8'h02, 8'h01, 1'b0);
    check_out("cmp", 8'h00, 1, 0, 0);

    // SHR: first load flagShift=1, then shift it in
    apply(SHR, 8'h01, 8'h00, 1'b0);
    check_out("shr0", 8'h00, 1, 1, 1);
    apply(SHR, 8'h03, 8'h00, 1'b0);
    check_out("shr1", 8'h81, 1, 1, 0);
    apply(SHR, 8'h02, 8'h00, 1'b0);
    check_out("shr2", 8'h81, 1, 0, 0);

    // Logic ops keep carry and shift flags
    apply(AND_, 8'hF0, 8'h3C, 1'b0);
    check_out("and", 8'h30, 1, 0, 0);
    apply(OR_, 8'h0F, 8'h30, 1'b0);
    check_out("or", 8'h3F, 1, 0, 0);
    apply(XOR_, 8'hAA, 8'hAA, 1'b0);
    check_out("xor", 8'h00, 1, 0, 1);

    // MUL 0x0F*0x11 with an ignored start and operand churn while busy
    apply(MUL, 8'h0F, 8'h11, 1'b0);
    a = 8'h55; b = 8'hAA;
    check("mul1.busy0", busy, 1);
    check("mul1.done0", done, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        @(negedge clk);
        start = 1'b1; op = ADD; a = 8'h01; b = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i < 8) begin
        check($sformatf("mul1.busy%0d", i), busy, 1);
        check($sformatf("mul1.done%0d", i), done, 0);
        check($sformatf("mul1.hold%0d", i), {resultHi, result, flagCarry}, 17'h1);
      end
    end
    check("mul1.busyend", busy, 0);
    check_out("mul1", 8'hFF, 0, 0, 0);
    check("mul1.hi", resultHi, 8'h00);
    @(posedge clk); #1;
    check("mul1.noqueue.done", done, 0);
    check("mul1.noqueue.busy", busy, 0);
    check("mul1.noqueue.res", result, 8'hFF);

    // MUL 0xFF*0xFF = 0xFE01
    apply(MUL, 8'hFF, 8'hFF, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
    end
    check_out("mul2", 8'h01, 1, 0, 0);
    check("mul2.hi", resultHi, 8'hFE);

    // Abort a MUL with an asynchronous mid-cycle reset at busy cycle 4
    apply(MUL, 8'h12, 8'h34, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
    end
    check("abort.busybefore", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.res", result, 0);
    check("abort.hi", resultHi, 0);
    check("abort.flags", {flagCarry, flagShift, flagZero}, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    check("abort.nodone", done, 0);
    apply(ADD, 8'h01, 8'h01, 1'b0);
    check_out("postrst", 8'h02, 0, 0, 0);
    check("postrst.busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
